cache_fill_fsm: RTL and testbench

- Miss-handling controller that sits directly upstream of the multi-cycle data memory (memory4c) and drives its read port.
- On a cache miss it issues one read per cycle for every word of the aligned block.
- It consumes the memory's pipelined data/valid returns and writes each returned word into the cache data array.
- After the final word it writes the tag array and releases the stall.

---
 rtl/cache_fill_fsm.sv | 99 +++++++++
 tb/tb_cache_fill_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_fill_fsm : cache miss block-fill controller for memory4c        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cache_fill_fsm #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_WIDTH-1:0]          miss_address,
    input  logic                           memory_data_valid,
    input  logic [15:0]                    memory_data,
    output logic                           fsm_busy,
    output logic                           mem_enable,
    output logic [ADDR_WIDTH-1:0]          memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] word_index,
    output logic [15:0]                    fill_data,
    output logic                           write_tag_array
);

    localparam int c_IDX_W = $clog2(BLOCK_WORDS);
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);
    localparam logic [c_CNT_W-1:0]    c_ISSUE_MAX = c_CNT_W'(BLOCK_WORDS);
    localparam logic [c_IDX_W-1:0]    c_RECV_LAST = c_IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_issue_cnt;
    logic [c_IDX_W-1:0]      r_recv_cnt;
    logic [ADDR_WIDTH-1:0]   r_base;

    logic                    w_active;
    logic                    w_issue;
    logic                    w_recv;
    logic                    w_last;

    // Outputs are forced quiet while rst_n is low, even mid-fill.
    assign w_active = (r_state == S_FILL) && rst_n;
    assign w_issue  = w_active && (r_issue_cnt < c_ISSUE_MAX);
    assign w_recv   = w_active && memory_data_valid;
    assign w_last   = w_recv && (r_recv_cnt == c_RECV_LAST);

    always_comb begin
        fsm_busy         = w_active;
        mem_enable       = w_issue;
        memory_address   = '0;
        write_data_array = w_recv;
        word_index       = r_recv_cnt;
        fill_data        = memory_data;
        write_tag_array  = w_last;
        if (w_issue) begin
            memory_address = r_base + ADDR_WIDTH'({r_issue_cnt, 1'b0});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_base      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_detected) begin
                        r_base      <= miss_address & ~c_OFF_MASK;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + c_CNT_W'(1);
                    end
                    // Receive count wraps to zero on the final word.
                    if (w_recv) begin
                        r_recv_cnt <= r_recv_cnt + c_IDX_W'(1);
                    end
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_fill_fsm : self-checking bench with 4-cycle memory model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cache_fill_fsm;

    localparam int c_BW  = 8;
    localparam int c_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_index;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(c_BW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data      (memory_data),
        .fsm_busy         (fsm_busy),
        .mem_enable       (mem_enable),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .word_index       (word_index),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Memory environment: fixed 4-cycle read latency, not cleared by reset.
    logic [c_LAT-1:0] r_pv;
    logic [15:0]      r_pa [c_LAT];
    logic             stray;
    initial r_pv = '0;
    always @(posedge clk) begin
        r_pv <= {r_pv[c_LAT-2:0], mem_enable};
        r_pa[0] <= memory_address;
        for (int i = 1; i < c_LAT; i++) r_pa[i] <= r_pa[i-1];
    end
    assign memory_data_valid = r_pv[c_LAT-1] | stray;
    assign memory_data       = stray ? 16'hDEAD : memfn(r_pa[c_LAT-1]);

    // Timeline model: fill cycle k runs 0..BW+LAT-1 after a miss is taken.
    bit          m_fill = 0;
    int          m_k    = 0;
    logic [15:0] m_base = '0;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_fill = 0;
        end else if (!m_fill) begin
            if (miss_detected) begin
                m_fill = 1;
                m_k    = 0;
                m_base = miss_address & 16'hFFF0;
            end
        end else if (m_k == c_BW + c_LAT - 1) begin
            m_fill = 0;
        end else begin
            m_k++;
        end
    end

    int          s_busy, s_en, s_wr, s_tag;
    logic [15:0] s_first, s_last, s_max;
    task automatic clear_stats();
        s_busy = 0; s_en = 0; s_wr = 0; s_tag = 0;
        s_first = '0; s_last = '0; s_max = '0;
    endtask

    bit          e_busy, e_en, e_wr, e_tag;
    logic [15:0] e_addr;
    always @(negedge clk) begin
        e_busy = rst_n && m_fill;
        e_en   = e_busy && (m_k < c_BW);
        e_addr = e_en ? m_base + 16'(2 * m_k) : 16'h0000;
        e_wr   = e_busy && (m_k >= c_LAT) && (m_k < c_BW + c_LAT);
        e_tag  = e_busy && (m_k == c_BW + c_LAT - 1);
        chk("fsm_busy",         32'(fsm_busy),         32'(e_busy));
        chk("mem_enable",       32'(mem_enable),       32'(e_en));
        chk("memory_address",   32'(memory_address),   32'(e_addr));
        chk("write_data_array", 32'(write_data_array), 32'(e_wr));
        chk("write_tag_array",  32'(write_tag_array),  32'(e_tag));
        if (e_wr && write_data_array) begin
            chk("word_index", 32'(word_index), 32'(m_k - c_LAT));
            chk("fill_data",  32'(fill_data),  32'(memfn(m_base + 16'(2 * (m_k - c_LAT)))));
        end
        if (fsm_busy) s_busy++;
        if (write_data_array) s_wr++;
        if (write_tag_array) s_tag++;
        if (mem_enable) begin
            if (s_en == 0) s_first = memory_address;
            s_last = memory_address;
            if (memory_address > s_max) s_max = memory_address;
            s_en++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_miss(input logic [15:0] a);
        @(posedge clk); #2;
        miss_detected = 1'b1;
        miss_address  = a;
        tick(1);
        miss_detected = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0; stray = 1'b0;
        clear_stats();
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic fill from an unaligned address.
        clear_stats();
        start_miss(16'h1236);
        tick(16);
        chk("basic_busy_cycles", 32'(s_busy), 32'd12);
        chk("basic_enables",     32'(s_en),   32'd8);
        chk("basic_writes",      32'(s_wr),   32'd8);
        chk("basic_tags",        32'(s_tag),  32'd1);
        chk("basic_first_addr",  32'(s_first), 32'h1230);
        chk("basic_last_addr",   32'(s_last),  32'h123E);

        // Miss held high: two back-to-back fills, with a stray miss at F3.
        clear_stats();
        @(posedge clk); #2;
        miss_detected = 1'b1;
        miss_address  = 16'h0040;
        tick(4);
        miss_address  = 16'h2000;
        tick(1);
        miss_address  = 16'h0040;
        tick(15);
        miss_detected = 1'b0;
        tick(20);
        chk("b2b_busy_cycles", 32'(s_busy), 32'd24);
        chk("b2b_writes",      32'(s_wr),   32'd16);
        chk("b2b_tags",        32'(s_tag),  32'd2);
        chk("b2b_first_addr",  32'(s_first), 32'h0040);
        chk("b2b_max_addr",    32'(s_max),   32'h004E);

        // Reset asserted during F6; later returns must be dropped.
        clear_stats();
        start_miss(16'h0800);
        tick(6);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(8);
        chk("rst_writes", 32'(s_wr),  32'd2);
        chk("rst_tags",   32'(s_tag), 32'd0);
        clear_stats();
        start_miss(16'h0100);
        tick(16);
        chk("post_rst_writes", 32'(s_wr),    32'd8);
        chk("post_rst_tags",   32'(s_tag),   32'd1);
        chk("post_rst_first",  32'(s_first), 32'h0100);

        // Top of memory.
        clear_stats();
        start_miss(16'hFFFF);
        tick(16);
        chk("top_first_addr", 32'(s_first), 32'hFFF0);
        chk("top_last_addr",  32'(s_last),  32'hFFFE);
        chk("top_writes",     32'(s_wr),    32'd8);
        chk("top_tags",       32'(s_tag),   32'd1);

        // Stray valid while idle.
        clear_stats();
        stray = 1'b1;
        tick(2);
        stray = 1'b0;
        tick(1);
        chk("stray_writes", 32'(s_wr),   32'd0);
        chk("stray_busy",   32'(s_busy), 32'd0);
        start_miss(16'h3456);
        tick(16);
        chk("stray_fill_writes", 32'(s_wr),    32'd8);
        chk("stray_fill_tags",   32'(s_tag),   32'd1);
        chk("stray_fill_first",  32'(s_first), 32'h3450);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
